clock_mode_fsm: RTL and testbench

//  Sits directly downstream of button_controller. Consumes its one-cycle button event pulses and runs the clock.

---
 rtl/clock_mode_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_clock_mode_fsm.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_fsm.sv
// Time-of-day clock with alarm, driven by button event pulses.
// Owns the prescaler, set/alarm-edit modes and alarm ring timing.
module clock_mode_fsm #(
  parameter int TICKS_PER_SEC = 1000000,
  parameter int RING_SECS     = 60
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       ev_set,
  input  logic       ev_alarm,
  input  logic       ev_b0,
  input  logic       ev_b1,
  output logic [2:0] mode,
  output logic [4:0] disp_hh,
  output logic [5:0] disp_mm,
  output logic [5:0] disp_ss,
  output logic       blink,
  output logic       sec_tick,
  output logic       alarm_en,
  output logic       alarm_ring
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RW = $clog2(RING_SECS + 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICKS_PER_SEC / 2);
  localparam logic [RW-1:0] RING_TOP = RW'(RING_SECS - 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_HH = 3'd1,
    SET_MM = 3'd2,
    ALM_HH = 3'd3,
    ALM_MM = 3'd4
  } mode_e;

  mode_e mode_q, mode_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    hh_q, hh_d;
  logic [5:0]    mm_q, mm_d;
  logic [5:0]    ss_q, ss_d;
  logic [4:0]    ahh_q, ahh_d;
  logic [5:0]    amm_q, amm_d;
  logic          en_q, en_d;
  logic          ring_q, ring_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;
  logic [4:0]    dhh_q, dhh_d;
  logic [5:0]    dmm_q, dmm_d;
  logic [5:0]    dss_q, dss_d;

  logic any_ev;
  logic act_set, act_alm, act_b0, act_b1;
  logic in_set, wrap, match;

  function automatic logic [5:0] inc_mod(
    input logic [5:0] v,
    input logic [5:0] top
  );
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_mod(
    input logic [5:0] v,
    input logic [5:0] top
  );
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  // A ringing alarm swallows every event; otherwise only the top one acts.
  assign any_ev  = ev_set | ev_alarm | ev_b0 | ev_b1;
  assign act_set = ~ring_q & ev_set;
  assign act_alm = ~ring_q & ~ev_set & ev_alarm;
  assign act_b0  = ~ring_q & ~ev_set & ~ev_alarm & ev_b0;
  assign act_b1  = ~ring_q & ~ev_set & ~ev_alarm & ~ev_b0 & ev_b1;

  assign in_set = (mode_q == SET_HH) || (mode_q == SET_MM);
  assign wrap   = ~in_set && (cnt_q == CNT_TOP);

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      mode_q  <= RUN;
      cnt_q   <= '0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      ahh_q   <= '0;
      amm_q   <= '0;
      en_q    <= 1'b0;
      ring_q  <= 1'b0;
      rcnt_q  <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b1;
      dhh_q   <= '0;
      dmm_q   <= '0;
      dss_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      ahh_q   <= ahh_d;
      amm_q   <= amm_d;
      en_q    <= en_d;
      ring_q  <= ring_d;
      rcnt_q  <= rcnt_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      dhh_q   <= dhh_d;
      dmm_q   <= dmm_d;
      dss_q   <= dss_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      RUN: begin
        if (act_set) mode_d = SET_HH;
        else if (act_alm) mode_d = ALM_HH;
      end
      SET_HH: if (act_set) mode_d = SET_MM;
      SET_MM: if (act_set) mode_d = RUN;
      ALM_HH: if (act_alm) mode_d = ALM_MM;
      ALM_MM: if (act_alm) mode_d = RUN;
      default: mode_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    hh_d   = hh_q;
    mm_d   = mm_q;
    ss_d   = ss_q;
    ahh_d  = ahh_q;
    amm_d  = amm_q;
    en_d   = en_q;
    ring_d = ring_q;
    rcnt_d = rcnt_q;

    if (!in_set) cnt_d = wrap ? '0 : cnt_q + 1'b1;

    if (wrap) begin
      if (ss_q == 6'd59) begin
        ss_d = 6'd0;
        if (mm_q == 6'd59) begin
          mm_d = 6'd0;
          hh_d = 5'(inc_mod({1'b0, hh_q}, 6'd23));
        end else begin
          mm_d = mm_q + 6'd1;
        end
      end else begin
        ss_d = ss_q + 6'd1;
      end
    end

    // Edits are applied after the carry so a stored edit beats it.
    unique case (mode_q)
      RUN: if (act_b0) en_d = ~en_q;
      SET_HH: begin
        if (act_b0) hh_d = 5'(inc_mod({1'b0, hh_q}, 6'd23));
        if (act_b1) hh_d = 5'(dec_mod({1'b0, hh_q}, 6'd23));
      end
      SET_MM: begin
        if (act_b0) mm_d = inc_mod(mm_q, 6'd59);
        if (act_b1) mm_d = dec_mod(mm_q, 6'd59);
        if (act_set) begin
          ss_d  = 6'd0;
          cnt_d = '0;
        end
      end
      ALM_HH: begin
        if (act_b0) ahh_d = 5'(inc_mod({1'b0, ahh_q}, 6'd23));
        if (act_b1) ahh_d = 5'(dec_mod({1'b0, ahh_q}, 6'd23));
      end
      ALM_MM: begin
        if (act_b0) amm_d = inc_mod(amm_q, 6'd59);
        if (act_b1) amm_d = dec_mod(amm_q, 6'd59);
      end
      default: ;
    endcase

    if (ring_q) begin
      if (any_ev) begin
        ring_d = 1'b0;
      end else if (tick_q) begin
        if (rcnt_q == RING_TOP) ring_d = 1'b0;
        else rcnt_d = rcnt_q + 1'b1;
      end
    end else if (match) begin
      ring_d = 1'b1;
      rcnt_d = '0;
    end
    if (!en_d) ring_d = 1'b0;
  end

  // Match is seen in the sec_tick cycle, so ring rises one cycle later.
  assign match = tick_q && en_q && !in_set && (ss_q == 6'd0) &&
                 (hh_q == ahh_q) && (mm_q == amm_q);

  always_comb begin
    tick_d  = wrap;
    blink_d = (cnt_d < CNT_HALF);
    dss_d   = ss_d;
    dhh_d   = hh_d;
    dmm_d   = mm_d;
    if ((mode_d == ALM_HH) || (mode_d == ALM_MM)) begin
      dhh_d = ahh_d;
      dmm_d = amm_d;
    end
  end

  assign mode       = mode_q;
  assign disp_hh    = dhh_q;
  assign disp_mm    = dmm_q;
  assign disp_ss    = dss_q;
  assign blink      = blink_q;
  assign sec_tick   = tick_q;
  assign alarm_en   = en_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_clock_mode_fsm.sv
// Directed bench for clock_mode_fsm with a 4-cycle second.
// Expected values are hand-computed cycle counts.
module tb_clock_mode_fsm;

  logic       mclk = 1'b0;
  logic       rst = 1'b0;
  logic       ev_set = 1'b0;
  logic       ev_alarm = 1'b0;
  logic       ev_b0 = 1'b0;
  logic       ev_b1 = 1'b0;
  logic [2:0] mode;
  logic [4:0] disp_hh;
  logic [5:0] disp_mm;
  logic [5:0] disp_ss;
  logic       blink;
  logic       sec_tick;
  logic       alarm_en;
  logic       alarm_ring;

  int n_tests = 0;
  int n_fail = 0;
  int ticks = 0;

  clock_mode_fsm #(
    .TICKS_PER_SEC(4),
    .RING_SECS(3)
  ) dut (
    .mclk(mclk),
    .rst(rst),
    .ev_set(ev_set),
    .ev_alarm(ev_alarm),
    .ev_b0(ev_b0),
    .ev_b1(ev_b1),
    .mode(mode),
    .disp_hh(disp_hh),
    .disp_mm(disp_mm),
    .disp_ss(disp_ss),
    .blink(blink),
    .sec_tick(sec_tick),
    .alarm_en(alarm_en),
    .alarm_ring(alarm_ring)
  );

  always #5 mclk = ~mclk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
      if (sec_tick) ticks++;
    end
  endtask

  task automatic press(
    input logic s,
    input logic a,
    input logic b0,
    input logic b1
  );
    ev_set   = s;
    ev_alarm = a;
    ev_b0    = b0;
    ev_b1    = b1;
    step(1);
    ev_set   = 1'b0;
    ev_alarm = 1'b0;
    ev_b0    = 1'b0;
    ev_b1    = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    step(2);
    chk("rst_mode", mode, 0);
    chk("rst_hh", disp_hh, 0);
    chk("rst_mm", disp_mm, 0);
    chk("rst_ss", disp_ss, 0);
    chk("rst_blink", blink, 1);
    chk("rst_tick", sec_tick, 0);
    chk("rst_en", alarm_en, 0);
    chk("rst_ring", alarm_ring, 0);

    // 1: free run
    rst = 1'b1;
    ticks = 0;
    step(240);
    chk("t1_ticks", ticks, 60);
    chk("t1_ss", disp_ss, 0);
    chk("t1_mm", disp_mm, 1);
    chk("t1_hh", disp_hh, 0);
    chk("t1_tick", sec_tick, 1);
    chk("t1_blink_hi", blink, 1);
    step(2);
    chk("t1_blink_lo", blink, 0);

    // 2: set time to 23:02
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    press(1, 0, 0, 0);
    chk("t2_mode_shh", mode, 1);
    ticks = 0;
    step(20);
    chk("t2_frozen_ss", disp_ss, 0);
    chk("t2_frozen_tk", ticks, 0);
    press(0, 0, 0, 1);
    chk("t2_hh_dec", disp_hh, 23);
    press(1, 0, 0, 0);
    chk("t2_mode_smm", mode, 2);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    chk("t2_mode", mode, 0);
    chk("t2_hh", disp_hh, 23);
    chk("t2_mm", disp_mm, 2);
    chk("t2_ss", disp_ss, 0);

    // 3: midnight rollover
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    chk("t3_mm_wrap", disp_mm, 59);
    press(1, 0, 0, 0);
    step(232);
    chk("t3_ss58", disp_ss, 58);
    ticks = 0;
    step(8);
    chk("t3_hh", disp_hh, 0);
    chk("t3_mm", disp_mm, 0);
    chk("t3_ss", disp_ss, 0);
    chk("t3_ticks", ticks, 2);

    // 4: alarm 01:01, ring, dismiss
    press(0, 1, 0, 0);
    chk("t4_mode_ahh", mode, 3);
    chk("t4_ahh0", disp_hh, 0);
    press(0, 0, 1, 0);
    chk("t4_ahh1", disp_hh, 1);
    press(0, 1, 0, 0);
    chk("t4_mode_amm", mode, 4);
    press(0, 0, 1, 0);
    chk("t4_amm1", disp_mm, 1);
    press(0, 1, 0, 0);
    chk("t4_mode_run", mode, 0);
    chk("t4_time_hh", disp_hh, 0);
    press(0, 0, 1, 0);
    chk("t4_en", alarm_en, 1);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    step(232);
    chk("t4_hh", disp_hh, 1);
    chk("t4_ss58", disp_ss, 58);
    step(7);
    chk("t4_ring_early", alarm_ring, 0);
    step(1);
    chk("t4_mm", disp_mm, 1);
    chk("t4_tick", sec_tick, 1);
    chk("t4_ring_tick", alarm_ring, 0);
    step(1);
    chk("t4_ring", alarm_ring, 1);
    press(0, 0, 0, 1);
    chk("t4_dismiss", alarm_ring, 0);
    chk("t4_en_kept", alarm_en, 1);

    // 5: ring times out after 3 ticks
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    press(1, 0, 0, 0);
    chk("t5_mm", disp_mm, 0);
    step(240);
    chk("t5_ring_tick", alarm_ring, 0);
    step(1);
    chk("t5_ring", alarm_ring, 1);
    ticks = 0;
    step(11);
    chk("t5_ring_hold", alarm_ring, 1);
    chk("t5_ticks", ticks, 3);
    step(1);
    chk("t5_ring_off", alarm_ring, 0);
    chk("t5_en", alarm_en, 1);
    press(0, 0, 1, 0);
    chk("t5_en_off", alarm_en, 0);

    // 6: arbitration and async reset mid-edit
    press(1, 0, 1, 0);
    chk("t6_mode", mode, 1);
    chk("t6_en", alarm_en, 0);
    press(1, 0, 0, 0);
    chk("t6_mode_smm", mode, 2);
    @(negedge mclk);
    rst = 1'b0;
    #1;
    chk("t6_rst_mode", mode, 0);
    chk("t6_rst_hh", disp_hh, 0);
    chk("t6_rst_mm", disp_mm, 0);
    chk("t6_rst_ss", disp_ss, 0);
    step(1);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
